// File: rtl/serial_bit_source.sv
// Parallel-to-serial feeder: valid/ready word intake, one-word holding register,
// MSB-first shift-out advanced by bit_en. Drives a bit-serial detector's din.
module serial_bit_source #(
  parameter int unsigned WIDTH    = 8,
  parameter logic        IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             bit_en,
  output logic             dout,
  output logic             dout_valid,
  output logic             word_done
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] hold_data, hold_data_next;
  logic             hold_full, hold_full_next;
  logic [WIDTH-1:0] shreg, shreg_next;
  logic [CW-1:0]    bit_cnt, bit_cnt_next;
  logic             word_done_next;
  logic             accept;

  // Ready comes only from registered state; a draining hold never opens it early.
  assign load_ready = !hold_full;
  assign accept     = load_valid && !hold_full;
  assign dout       = (state == SHIFT) ? shreg[WIDTH-1] : IDLE_BIT;
  assign dout_valid = (state == SHIFT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      hold_data <= '0;
      hold_full <= 1'b0;
      shreg     <= '0;
      bit_cnt   <= '0;
      word_done <= 1'b0;
    end else begin
      state     <= state_next;
      hold_data <= hold_data_next;
      hold_full <= hold_full_next;
      shreg     <= shreg_next;
      bit_cnt   <= bit_cnt_next;
      word_done <= word_done_next;
    end
  end

  always_comb begin
    state_next     = state;
    hold_data_next = hold_data;
    hold_full_next = hold_full;
    shreg_next     = shreg;
    bit_cnt_next   = bit_cnt;
    word_done_next = 1'b0;

    // Accept never coincides with a hold->shifter transfer: both need opposite hold_full.
    if (accept) begin
      hold_data_next = load_data;
      hold_full_next = 1'b1;
    end

    unique case (state)
      IDLE: begin
        if (hold_full) begin
          shreg_next     = hold_data;
          bit_cnt_next   = CW'(WIDTH - 1);
          hold_full_next = 1'b0;
          state_next     = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_en) begin
          if (bit_cnt != '0) begin
            shreg_next   = {shreg[WIDTH-2:0], 1'b0};
            bit_cnt_next = bit_cnt - 1'b1;
          end else begin
            word_done_next = 1'b1;
            if (hold_full) begin
              shreg_next     = hold_data;
              bit_cnt_next   = CW'(WIDTH - 1);
              hold_full_next = 1'b0;
            end else begin
              state_next = IDLE;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_bit_source.sv
// Bench for serial_bit_source: WIDTH=4 and WIDTH=8 instances, a bit scoreboard
// fed on accept and drained on bit consumption, plus vector table and corner sequences.
module tb_serial_bit_source;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] lv, en, rdy, dbit, dv, wd;
  logic [3:0] ld4;
  logic [7:0] ld8;

  int errors = 0;
  int checks = 0;

  logic q4[$];
  logic q8[$];

  logic [3:0] hist;
  int         det_cnt;

  always #5 clk = ~clk;

  serial_bit_source #(.WIDTH(4), .IDLE_BIT(1'b0)) u4 (
    .clk(clk), .reset(reset), .load_valid(lv[0]), .load_data(ld4), .load_ready(rdy[0]),
    .bit_en(en[0]), .dout(dbit[0]), .dout_valid(dv[0]), .word_done(wd[0])
  );

  serial_bit_source #(.WIDTH(8), .IDLE_BIT(1'b0)) u8 (
    .clk(clk), .reset(reset), .load_valid(lv[1]), .load_data(ld8), .load_ready(rdy[1]),
    .bit_en(en[1]), .dout(dbit[1]), .dout_valid(dv[1]), .word_done(wd[1])
  );

  // Reference 1010 detector on the WIDTH=4 stream, stepping on each consumed bit.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      hist    <= 4'b0;
      det_cnt <= 0;
    end else if (dv[0] && en[0]) begin
      hist <= {hist[2:0], dbit[0]};
      if ({hist[2:0], dbit[0]} == 4'b1010) det_cnt <= det_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sb_pop(input int s);
    logic e;
    if (s == 0) begin
      if (q4.size() == 0) begin chk("sb_extra_w4", 1, 0); return; end
      e = q4.pop_front();
    end else begin
      if (q8.size() == 0) begin chk("sb_extra_w8", 1, 0); return; end
      e = q8.pop_front();
    end
    chk(s == 0 ? "sb_bit_w4" : "sb_bit_w8", dbit[s], e);
  endtask

  // Scoreboard bookkeeping for the cycle about to end, then advance one clock.
  task automatic step();
    if (!reset) begin
      if (lv[0] && rdy[0]) for (int i = 3; i >= 0; i--) q4.push_back(ld4[i]);
      if (lv[1] && rdy[1]) for (int i = 7; i >= 0; i--) q8.push_back(ld8[i]);
      for (int s = 0; s < 2; s++) begin
        if (dv[s] && en[s]) sb_pop(s);
        else if (!dv[s]) chk("idle_bit", dbit[s], 0);
      end
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int         sel;
    logic [7:0] word;
    int         period;
    logic [7:0] exp;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int w;
    int n;
    w = (v.sel == 0) ? 4 : 8;
    n = 0;
    while (!rdy[v.sel] && n < 40) begin step(); n++; end
    chk("vec_ready", rdy[v.sel], 1);
    lv[v.sel] = 1'b1;
    en[v.sel] = 1'b0;
    if (v.sel == 0) ld4 = v.word[3:0]; else ld8 = v.word;
    step();
    lv[v.sel] = 1'b0;
    chk("vec_lat_valid", dv[v.sel], 0);
    chk("vec_lat_ready", rdy[v.sel], 0);
    step();
    chk("vec_ready_back", rdy[v.sel], 1);
    for (int b = w - 1; b >= 0; b--) begin
      for (int c = 0; c < v.period; c++) begin
        chk("vec_dout", dbit[v.sel], v.exp[b]);
        chk("vec_valid", dv[v.sel], 1);
        chk("vec_wd_low", wd[v.sel], 0);
        en[v.sel] = (c == v.period - 1);
        step();
      end
    end
    en[v.sel] = 1'b0;
    chk("vec_wd_pulse", wd[v.sel], 1);
    chk("vec_end_valid", dv[v.sel], 0);
    step();
    chk("vec_wd_clear", wd[v.sel], 0);
  endtask

  vec_t vecs[6];
  logic [7:0] bb_dout;
  logic [7:0] bb_rdy;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{sel: 0, word: 8'h0A, period: 1, exp: 8'b0000_1010};
    vecs[1] = '{sel: 0, word: 8'h06, period: 2, exp: 8'b0000_0110};
    vecs[2] = '{sel: 0, word: 8'h0F, period: 1, exp: 8'b0000_1111};
    vecs[3] = '{sel: 0, word: 8'h00, period: 3, exp: 8'b0000_0000};
    vecs[4] = '{sel: 1, word: 8'hA5, period: 3, exp: 8'b1010_0101};
    vecs[5] = '{sel: 1, word: 8'h3C, period: 1, exp: 8'b0011_1100};
    bb_dout = 8'b1100_0011;
    bb_rdy  = 8'b1000_1111;

    reset = 1'b1; lv = '0; en = '0; ld4 = '0; ld8 = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      for (int s = 0; s < 2; s++) begin
        chk("rst_ready", rdy[s], 1);
        chk("rst_dout", dbit[s], 0);
        chk("rst_valid", dv[s], 0);
        chk("rst_wd", wd[s], 0);
      end
      step();
    end

    foreach (vecs[i]) begin
      run_vec(vecs[i]);
      if (i == 0) chk("det_1010_once", det_cnt, 1);
    end

    // Back-to-back 1100 then 0011 on WIDTH=4 with bit_en held high.
    en[0] = 1'b1; lv[0] = 1'b1; ld4 = 4'b1100;
    step();
    chk("bb_full_ready", rdy[0], 0);
    chk("bb_pre_valid", dv[0], 0);
    ld4 = 4'b0011;
    step();
    for (int k = 1; k <= 8; k++) begin
      if (k == 2) lv[0] = 1'b0;
      chk("bb_dout", dbit[0], bb_dout[8-k]);
      chk("bb_valid", dv[0], 1);
      chk("bb_wd", wd[0], (k == 5) ? 1 : 0);
      chk("bb_ready", rdy[0], bb_rdy[8-k]);
      step();
    end
    chk("bb_wd_last", wd[0], 1);
    chk("bb_end_valid", dv[0], 0);
    chk("bb_end_ready", rdy[0], 1);
    en[0] = 1'b0;
    step();
    chk("bb_wd_clear", wd[0], 0);

    // Offer a third word while hold is full and the shifter is stalled.
    lv[0] = 1'b1; ld4 = 4'b1001;
    step();
    ld4 = 4'b0110;
    step();
    step();
    chk("hf_ready_low", rdy[0], 0);
    ld4 = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hf_no_accept", rdy[0], 0);
      chk("hf_dout_stable", dbit[0], 1);
      chk("hf_valid", dv[0], 1);
    end
    lv[0] = 1'b0; en[0] = 1'b1;
    for (int i = 0; i < 10; i++) step();
    en[0] = 1'b0;
    chk("hf_drained", q4.size(), 0);
    chk("hf_idle", dv[0], 0);

    // Asynchronous reset after 2 of 8 bits with a second word in hold.
    lv[1] = 1'b1; ld8 = 8'h96; en[1] = 1'b0;
    step();
    step();
    ld8 = 8'h5A;
    step();
    lv[1] = 1'b0;
    chk("mr_hold_full", rdy[1], 0);
    en[1] = 1'b1;
    step();
    step();
    en[1] = 1'b0;
    chk("mr_mid_valid", dv[1], 1);
    #3 reset = 1'b1;
    #1;
    chk("mr_ready", rdy[1], 1);
    chk("mr_dout", dbit[1], 0);
    chk("mr_valid", dv[1], 0);
    chk("mr_wd", wd[1], 0);
    q4.delete();
    q8.delete();
    step();
    reset = 1'b0;
    step();
    chk("mr_post_valid", dv[1], 0);
    run_vec('{sel: 1, word: 8'hFF, period: 1, exp: 8'b1111_1111});
    step();
    chk("mr_no_residue", dv[1], 0);
    chk("final_q4_empty", q4.size(), 0);
    chk("final_q8_empty", q8.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_bit_source.md
# serial_bit_source

Upstream feeder for the team's bit-serial sequence detectors. Accepts parallel words over a valid/ready handshake and serialises them MSB-first onto a single-bit stream, one bit per `bit_en` strobe. Its `dout` drives the detector's `din` directly.
- A one-word holding register sits in front of the shift register, so consecutive words stream with no idle gap.

## Interface
Parameters:
- `WIDTH`, 8: bits per word; legal range 2..32.
- `IDLE_BIT`, 1'b0: value driven on `dout` when no word is being shifted.

Ports:
- `clk`  input  1  single clock; all state changes on its rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `load_valid`  input  1  upstream presents a word on `load_data`.
- `load_data`  input  WIDTH  word to serialise; bit WIDTH-1 is sent first.
- `load_ready`  output  1  holding register empty; word accepted when `load_valid && load_ready` at a rising edge.
- `bit_en`  input  1  bit strobe; advances the shifter by one bit when SHIFT.
- `dout`  output  1  current serial bit; feeds detector `din`.
- `dout_valid`  output  1  high while `dout` carries a data bit (state SHIFT).
- `word_done`  output  1  one-cycle pulse at the cycle after the last bit of a word is consumed.

## Operation
- Registers:
  - `hold_data[WIDTH-1:0]` and `hold_full`.
  - `shreg[WIDTH-1:0]`.
  - `bit_cnt` (clog2(WIDTH) bits).
  - state {IDLE, SHIFT}.
  - `word_done` register.
- Combinational outputs:
  - `load_ready = !hold_full`, depending only on registered state. There is no same-cycle pass-through: a word draining from hold does not open ready in that cycle.
  - `dout = (state==SHIFT) ? shreg[WIDTH-1] : IDLE_BIT`.
  - `dout_valid = (state==SHIFT)`.
- Handshake:
  - On `load_valid && load_ready`, `hold_data <= load_data` and `hold_full <= 1`.
  - `load_data` is don't-care when not accepted.
- IDLE:
  - If `hold_full`, then `shreg <= hold_data`, `bit_cnt <= WIDTH-1`, `hold_full <= 0`, and the next state is SHIFT.
  - `bit_en` is ignored in IDLE.
- SHIFT, with `bit_en` and `bit_cnt != 0`:
  - `shreg <= shreg << 1` (zero fill).
  - `bit_cnt <= bit_cnt - 1`.
- SHIFT, with `bit_en` and `bit_cnt == 0` (last bit consumed):
  - `word_done <= 1`.
  - If `hold_full`: reload `shreg`/`bit_cnt` from hold, clear `hold_full`, stay in SHIFT. This gives gapless back-to-back words.
  - Else: go to IDLE.
- SHIFT without `bit_en`: hold all state; `dout` stays stable.
- `word_done` is 0 on every edge not covered by the last-bit case.
- Simultaneous events:
  - Accept into hold and hold→shifter transfer cannot coincide, because accept requires `hold_full == 0`.
  - Accept while shifting is legal and fills hold for the next reload.
- Reset, asynchronous and at any time including mid-word:
  - state=IDLE, `hold_full`=0, `shreg`=0, `bit_cnt`=0, `word_done`=0.
  - Outputs become `load_ready`=1, `dout`=IDLE_BIT, `dout_valid`=0, `word_done`=0.
  - In-flight and held words are discarded.

## Timing
- Accept at edge E with the shifter IDLE:
  - Transfer to the shifter at edge E+1.
  - First bit on `dout` with `dout_valid`=1 from E+1 until the next `bit_en` edge.
  - `load_ready` returns high after E+1.
- With `bit_en` held high, each bit lasts exactly 1 cycle and a word occupies WIDTH cycles.
- `word_done` is high in the cycle after the edge that consumed the last bit.
- Sustained throughput is 1 bit/cycle, provided upstream re-presents within WIDTH-1 cycles of each accept.
- Latency from accept to first bit is 1 cycle when idle.

## Test plan
- Reset, then idle for 5 cycles -> `load_ready`=1, `dout`=IDLE_BIT, `dout_valid`=0, `word_done`=0 throughout.
- WIDTH=4, load 4'b1010 with `bit_en`=1 constantly:
  - `dout` = 1,0,1,0 on the 4 cycles after transfer, with `dout_valid` high for exactly 4 cycles.
  - `word_done` pulses once.
  - A downstream 1010 Moore detector asserts `detect` once.
- WIDTH=4, two words 4'b1100 then 4'b0011 accepted back-to-back, `bit_en`=1:
  - `dout` = 1,1,0,0,0,0,1,1 with no gap.
  - `dout_valid` high for 8 consecutive cycles.
  - `word_done` pulses after bits 4 and 8.
  - `load_ready` low while hold is full.
- WIDTH=8, word 8'hA5, `bit_en` asserted every 3rd cycle:
  - Each bit is held stable for 3 cycles.
  - The sequence is 1,0,1,0,0,1,0,1.
- Assert `reset` asynchronously mid-word, after 2 of 8 bits, with hold also full:
  - Outputs go to reset values immediately, before the next edge.
  - After release, the next accepted word 8'hFF shifts out cleanly with no residue of the aborted or held words.
- `load_valid` high while hold is full -> no accept, and `hold_data` stays unchanged.
